retire_serializer: RTL and testbench
====================================

# retire_serializer

Parametrised successor to the two-port retirement multiplexer. It takes up to `NrRetiredInstr` retired instructions per cycle from the commit stage, buffers each retirement row in an internal `Depth`-entry FIFO, and emits one instruction per cycle to the trace encoder over a valid/ready handshake. Slots that did not retire are skipped, and the shared fields (cause, tval, priv) are repeated for every emitted instruction. It sits between the CVA6 commit ports and the trace_encoder ingress.

## Interface
- `NrRetiredInstr`, 2: number of commit ports N, ≥1 (N=1 is a plain buffered pass-through).
- `Depth`, 8: FIFO depth in rows, a power of two ≥2.
- Widths `ITYPE_LEN`, `CAUSE_LEN`, `TVAL_LEN`, `PRIV_LEN`, `XLEN` come from `mure_pkg`.
- Clock and reset: reset `rst_ni`, asynchronous, active-low; clock `clk_i`.
- `flush_i` in 1: synchronous clear of the FIFO and of any row in progress.
- `iretire_i` in N: per-slot retire valid.
- `ilastsize_i` in N: per-slot last-instruction size (0 = 16-bit, 1 = 32-bit).
- `itype_i` in N×ITYPE_LEN: per-slot instruction type.
- `iaddr_i` in N×XLEN: per-slot instruction address.
- `cause_i`, `tval_i`, `priv_i` in CAUSE_LEN/TVAL_LEN/PRIV_LEN: fields common to the row.
- `valid_o` out 1: an output instruction is presented.
- `ready_i` in 1: the encoder accepts it.
- `ilastsize_o`, `itype_o`, `iaddr_o`, `cause_o`, `tval_o`, `priv_o` out: the emitted instruction.
- `slot_o` out max(1,$clog2(N)): index of the commit port being emitted.
- `full_o` out 1: FIFO holds `Depth` rows.
- `overflow_o` out 1: sticky flag, set when a row is dropped; cleared only by reset or `flush_i`.
- `drop_cnt_o` out 16: dropped-row counter (see Configuration).

## Operation
- A row is pushed when |`iretire_i` and either (`!full_o`) or (the head row's last slot handshakes this cycle). Rows with no retiring slot are never stored.
- A row that would be pushed while the FIFO is full and no pop occurs is dropped: `overflow_o` <= 1 and `drop_cnt_o` increments.
- A row stores the per-slot fields, the `iretire_i` mask, and the common fields.
- Output FSM:
  - IDLE: `valid_o`=0. When the FIFO is non-empty, load the head mask into `pend_q` and go to EMIT.
  - EMIT: the selected slot is the lowest set bit of `pend_q`, output on `slot_o`. `valid_o`=1 and the outputs come from that slot plus the row's common fields.
  - On `valid_o && ready_i`, clear that bit.
  - If the bit was the last one, pop the row. If another row is present, load its mask in the same cycle and stay in EMIT (no bubble); otherwise go to IDLE.
- The outputs stay stable while `valid_o && !ready_i`.
- `flush_i` has priority over push and pop in the same cycle. It empties the FIFO, sends the FSM to IDLE, and clears `overflow_o` and `drop_cnt_o`.
- Reset gives the same state as a flush. Every output resets to 0.
- The FIFO pointers are $clog2(Depth) bits and wrap modulo `Depth`. The usage counter is $clog2(Depth)+1 bits.
- `drop_cnt_o` saturates at 16'hFFFF.

## Timing
- Latency: a row pushed in cycle t has its first slot on `valid_o` in cycle t+1. There is no combinational path from input to output.
- Throughput: one instruction per cycle while `ready_i`=1. A row with k set slots occupies k output cycles.
- `full_o` is registered; it reflects usage after the updates of the previous edge.
- Simultaneous push and last-slot pop on a full FIFO: the push is accepted, usage stays at `Depth`, and no drop is counted.
- Reset asserted mid-row aborts the row immediately. The row is not replayed after reset.
- `ready_i` may toggle freely. `valid_o` never deasserts without a handshake, except on `flush_i` or reset.

## Configuration
- `RETIRE_SER_DROP_CNT_EN` defined: the 16-bit saturating dropped-row counter is implemented and drives `drop_cnt_o`.
- Not defined: no counter flops are instantiated and `drop_cnt_o` is tied to 16'h0000. `overflow_o` behaves the same in both builds.

## Test plan
All scenarios use N=2, Depth=4.
- Single row, `iretire_i`=2'b11, `iaddr_i`={0x1004,0x1000}, `ready_i`=1 → cycle t+1: `slot_o`=0, `iaddr_o`=0x1000; cycle t+2: `slot_o`=1, `iaddr_o`=0x1004; cycle t+3: `valid_o`=0.
- Sparse row `iretire_i`=2'b10 → a single output with `slot_o`=1; row `iretire_i`=2'b00 → nothing stored, `valid_o` stays 0.
- Back-pressure: hold `ready_i`=0 for 5 cycles with `valid_o`=1 → outputs unchanged throughout. Release → the emission order is preserved.
- Overflow: `ready_i`=0 and push 6 rows of 2'b01 → `full_o`=1 after the 4th row, `overflow_o`=1, `drop_cnt_o`=2 (0 when the macro is undefined). Release → exactly 4 outputs.
- Full plus pop in the same cycle: FIFO full and head with one slot left, `ready_i`=1 and a new row pushed → row accepted, `drop_cnt_o` unchanged, `full_o` stays 1.
- Flush and reset mid-row: with `valid_o`=1, assert `flush_i` → next cycle `valid_o`=0, `full_o`=0, `overflow_o`=0. Repeat with `rst_ni`=0 → all outputs 0 asynchronously.

Source files
------------

// File: rtl/mure_pkg.sv
// mure_pkg: field widths shared by the trace ingress path (commit ports,
// retire serializer and trace encoder).
package mure_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned ITYPE_LEN = 3;
  localparam int unsigned CAUSE_LEN = 5;
  localparam int unsigned TVAL_LEN  = 64;
  localparam int unsigned PRIV_LEN  = 2;

endpackage

// File: rtl/retire_serializer.sv
// retire_serializer
//
// Buffers up to NrRetiredInstr retired instructions per cycle (one "row")
// in a Depth-row FIFO and emits them one at a time to the trace encoder
// over a valid/ready handshake. Non-retiring slots are skipped; the common
// fields (cause, tval, priv) are repeated on every emitted instruction.
//
// Parameters
//   NrRetiredInstr : number of commit ports N (>= 1)
//   Depth          : FIFO depth in rows (power of two, >= 2)
//
// Ports
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   flush_i                 : synchronous clear of FIFO and row in progress
//   iretire_i[N]            : per-slot retire valid
//   ilastsize_i[N]          : per-slot last size (0 = 16-bit, 1 = 32-bit)
//   itype_i[N], iaddr_i[N]  : per-slot instruction type / address
//   cause_i, tval_i, priv_i : fields common to the row
//   valid_o / ready_i       : output handshake
//   ilastsize_o, itype_o, iaddr_o, cause_o, tval_o, priv_o : emitted instr
//   slot_o                  : commit-port index of the emitted instruction
//   full_o                  : FIFO holds Depth rows (registered)
//   overflow_o              : sticky, a row was dropped
//   drop_cnt_o              : saturating dropped-row counter
//
// Build option
//   RETIRE_SER_DROP_CNT_EN : when defined, implements the 16-bit saturating
//                            dropped-row counter; otherwise drop_cnt_o = 0.
module retire_serializer
  import mure_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned Depth          = 8,
  localparam int unsigned SlotW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          flush_i,
  input  logic [NrRetiredInstr-1:0]                     iretire_i,
  input  logic [NrRetiredInstr-1:0]                     ilastsize_i,
  input  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]      itype_i,
  input  logic [NrRetiredInstr-1:0][XLEN-1:0]           iaddr_i,
  input  logic [CAUSE_LEN-1:0]                          cause_i,
  input  logic [TVAL_LEN-1:0]                           tval_i,
  input  logic [PRIV_LEN-1:0]                           priv_i,
  output logic                                          valid_o,
  input  logic                                          ready_i,
  output logic                                          ilastsize_o,
  output logic [ITYPE_LEN-1:0]                          itype_o,
  output logic [XLEN-1:0]                               iaddr_o,
  output logic [CAUSE_LEN-1:0]                          cause_o,
  output logic [TVAL_LEN-1:0]                           tval_o,
  output logic [PRIV_LEN-1:0]                           priv_o,
  output logic [SlotW-1:0]                              slot_o,
  output logic                                          full_o,
  output logic                                          overflow_o,
  output logic [15:0]                                   drop_cnt_o
);

  localparam int unsigned N    = NrRetiredInstr;
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [0:0] Idle = 1'b0;
  localparam logic [0:0] Emit = 1'b1;

  typedef struct packed {
    logic [N-1:0]                mask;
    logic [N-1:0]                lastsize;
    logic [N-1:0][ITYPE_LEN-1:0] itype;
    logic [N-1:0][XLEN-1:0]      iaddr;
    logic [CAUSE_LEN-1:0]        cause;
    logic [TVAL_LEN-1:0]         tval;
    logic [PRIV_LEN-1:0]         priv;
  } row_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [SlotW-1:0] lowest_set(input logic [N-1:0] m);
    logic [SlotW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) idx = SlotW'(i);
    end
    return idx;
  endfunction

  row_t             mem_q [Depth];
  row_t             in_row;
  row_t             head_row;

  logic [0:0]       state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  usage_q, usage_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;

  logic [SlotW-1:0] sel_idx;
  logic [N-1:0]     sel_onehot;
  logic             emit, hs, last, pop, any_ret, push, drop;

  assign in_row.mask     = iretire_i;
  assign in_row.lastsize = ilastsize_i;
  assign in_row.itype    = itype_i;
  assign in_row.iaddr    = iaddr_i;
  assign in_row.cause    = cause_i;
  assign in_row.tval     = tval_i;
  assign in_row.priv     = priv_i;

  assign head_row   = mem_q[rd_ptr_q];
  assign sel_idx    = lowest_set(pend_q);
  assign sel_onehot = N'(1) << sel_idx;

  assign emit    = (state_q == Emit);
  assign hs      = emit & ready_i;
  // Only one pending bit left: this handshake finishes the row.
  assign last    = ((pend_q & (pend_q - N'(1))) == '0);
  assign pop     = hs & last;
  assign any_ret = |iretire_i;
  // A full FIFO still accepts a row when the head row retires this cycle.
  assign push    = any_ret & (~full_q | pop);
  assign drop    = any_ret & full_q & ~pop;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    usage_d    = usage_q;
    full_d     = full_q;
    overflow_d = overflow_q;

    if (flush_i) begin
      state_d    = Idle;
      pend_d     = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      usage_d    = '0;
      full_d     = 1'b0;
      overflow_d = 1'b0;
    end else begin
      wr_ptr_d   = wr_ptr_q + PtrW'(push);
      rd_ptr_d   = rd_ptr_q + PtrW'(pop);
      usage_d    = usage_q + CntW'(push) - CntW'(pop);
      full_d     = (usage_d == CntW'(Depth));
      overflow_d = overflow_q | drop;

      // Whenever a new row becomes head, its mask is loaded on the same
      // edge. If the FIFO would otherwise be empty, the row being pushed
      // is taken straight from the inputs, giving one-cycle latency.
      if (!emit || pop) begin
        if ((usage_q - CntW'(pop)) != '0) begin
          state_d = Emit;
          pend_d  = mem_q[rd_ptr_d].mask;
        end else if (push) begin
          state_d = Emit;
          pend_d  = iretire_i;
        end else begin
          state_d = Idle;
          pend_d  = '0;
        end
      end else if (hs) begin
        pend_d = pend_q & ~sel_onehot;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      pend_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      usage_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      usage_q    <= usage_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Row storage carries data only and is never reset; the output mux below
  // masks it whenever nothing is presented.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= in_row;
    end
  end

  always_comb begin
    ilastsize_o = 1'b0;
    itype_o     = '0;
    iaddr_o     = '0;
    cause_o     = '0;
    tval_o      = '0;
    priv_o      = '0;
    slot_o      = '0;
    if (emit) begin
      ilastsize_o = head_row.lastsize[sel_idx];
      itype_o     = head_row.itype[sel_idx];
      iaddr_o     = head_row.iaddr[sel_idx];
      cause_o     = head_row.cause;
      tval_o      = head_row.tval;
      priv_o      = head_row.priv;
      slot_o      = sel_idx;
    end
  end

  assign valid_o    = emit;
  assign full_o     = full_q;
  assign overflow_o = overflow_q;

`ifdef RETIRE_SER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_retire_serializer.sv
// Directed testbench for retire_serializer, configured with two commit
// ports and a four-row FIFO.
module tb_retire_serializer;
  import mure_pkg::*;

`ifdef RETIRE_SER_DROP_CNT_EN
  localparam logic [15:0] DROP1 = 16'd1;
  localparam logic [15:0] DROP2 = 16'd2;
`else
  localparam logic [15:0] DROP1 = 16'd0;
  localparam logic [15:0] DROP2 = 16'd0;
`endif

  logic                           clk_i;
  logic                           rst_ni;
  logic                           flush_i;
  logic [1:0]                     iretire_i;
  logic [1:0]                     ilastsize_i;
  logic [1:0][ITYPE_LEN-1:0]      itype_i;
  logic [1:0][XLEN-1:0]           iaddr_i;
  logic [CAUSE_LEN-1:0]           cause_i;
  logic [TVAL_LEN-1:0]            tval_i;
  logic [PRIV_LEN-1:0]            priv_i;
  logic                           valid_o;
  logic                           ready_i;
  logic                           ilastsize_o;
  logic [ITYPE_LEN-1:0]           itype_o;
  logic [XLEN-1:0]                iaddr_o;
  logic [CAUSE_LEN-1:0]           cause_o;
  logic [TVAL_LEN-1:0]            tval_o;
  logic [PRIV_LEN-1:0]            priv_o;
  logic [0:0]                     slot_o;
  logic                           full_o;
  logic                           overflow_o;
  logic [15:0]                    drop_cnt_o;

  int n_cmp;
  int n_err;

  retire_serializer #(
    .NrRetiredInstr(2),
    .Depth         (4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .iretire_i  (iretire_i),
    .ilastsize_i(ilastsize_i),
    .itype_i    (itype_i),
    .iaddr_i    (iaddr_i),
    .cause_i    (cause_i),
    .tval_i     (tval_i),
    .priv_i     (priv_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .ilastsize_o(ilastsize_o),
    .itype_o    (itype_o),
    .iaddr_o    (iaddr_o),
    .cause_o    (cause_o),
    .tval_o     (tval_o),
    .priv_o     (priv_o),
    .slot_o     (slot_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic drive_row(input logic [1:0] m, input logic [XLEN-1:0] a1,
                           input logic [XLEN-1:0] a0);
    iretire_i  = m;
    iaddr_i[1] = a1;
    iaddr_i[0] = a0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    n_cmp++; if (drop_cnt_o !== 16'h0) begin n_err++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt_o); end
    n_cmp++; if (iaddr_o !== '0) begin n_err++; $display("FAIL reset_iaddr: got %h want 0", iaddr_o); end
    n_cmp++; if (slot_o !== 1'b0) begin n_err++; $display("FAIL reset_slot: got %b want 0", slot_o); end
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_single_row();
    ready_i     = 1'b1;
    drive_row(2'b11, 64'h1004, 64'h1000);
    itype_i[1]  = 3'd2;
    itype_i[0]  = 3'd1;
    ilastsize_i = 2'b10;
    cause_i     = 5'd5;
    tval_i      = 64'hDEAD;
    priv_i      = 2'd3;
    tick();
    iretire_i = 2'b00;
    cause_i   = 5'd0;
    tval_i    = '0;
    priv_i    = '0;
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL single_t1_valid: got %b want 1", valid_o); end
    n_cmp++; if (slot_o !== 1'b0) begin n_err++; $display("FAIL single_t1_slot: got %0d want 0", slot_o); end
    n_cmp++; if (iaddr_o !== 64'h1000) begin n_err++; $display("FAIL single_t1_iaddr: got %h want 1000", iaddr_o); end
    n_cmp++; if (itype_o !== 3'd1) begin n_err++; $display("FAIL single_t1_itype: got %0d want 1", itype_o); end
    n_cmp++; if (ilastsize_o !== 1'b0) begin n_err++; $display("FAIL single_t1_lastsize: got %b want 0", ilastsize_o); end
    n_cmp++; if (cause_o !== 5'd5) begin n_err++; $display("FAIL single_t1_cause: got %0d want 5", cause_o); end
    tick();
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL single_t2_valid: got %b want 1", valid_o); end
    n_cmp++; if (slot_o !== 1'b1) begin n_err++; $display("FAIL single_t2_slot: got %0d want 1", slot_o); end
    n_cmp++; if (iaddr_o !== 64'h1004) begin n_err++; $display("FAIL single_t2_iaddr: got %h want 1004", iaddr_o); end
    n_cmp++; if (itype_o !== 3'd2) begin n_err++; $display("FAIL single_t2_itype: got %0d want 2", itype_o); end
    n_cmp++; if (ilastsize_o !== 1'b1) begin n_err++; $display("FAIL single_t2_lastsize: got %b want 1", ilastsize_o); end
    n_cmp++; if (cause_o !== 5'd5 || tval_o !== 64'hDEAD || priv_o !== 2'd3) begin
      n_err++; $display("FAIL single_t2_common: got %0d/%h/%0d want 5/dead/3", cause_o, tval_o, priv_o);
    end
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL single_t3_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_sparse();
    ready_i = 1'b1;
    drive_row(2'b10, 64'h2004, 64'h2000);
    tick();
    iretire_i = 2'b00;
    n_cmp++; if (valid_o !== 1'b1) begin n_err++; $display("FAIL sparse_valid: got %b want 1", valid_o); end
    n_cmp++; if (slot_o !== 1'b1) begin n_err++; $display("FAIL sparse_slot: got %0d want 1", slot_o); end
    n_cmp++; if (iaddr_o !== 64'h2004) begin n_err++; $display("FAIL sparse_iaddr: got %h want 2004", iaddr_o); end
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL sparse_end_valid: got %b want 0", valid_o); end
    drive_row(2'b00, 64'h2104, 64'h2100);
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL empty_row_valid0: got %b want 0", valid_o); end
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL empty_row_valid1: got %b want 0", valid_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL empty_row_full: got %b want 0", full_o); end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    drive_row(2'b11, 64'h3004, 64'h3000);
    tick();
    iretire_i = 2'b00;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (valid_o !== 1'b1 || slot_o !== 1'b0 || iaddr_o !== 64'h3000) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%b s=%0d a=%h want v=1 s=0 a=3000", i, valid_o, slot_o, iaddr_o);
      end
      tick();
    end
    ready_i = 1'b1;
    n_cmp++; if (iaddr_o !== 64'h3000) begin n_err++; $display("FAIL bp_release0: got %h want 3000", iaddr_o); end
    tick();
    n_cmp++; if (valid_o !== 1'b1 || slot_o !== 1'b1 || iaddr_o !== 64'h3004) begin
      n_err++; $display("FAIL bp_release1: got v=%b s=%0d a=%h want v=1 s=1 a=3004", valid_o, slot_o, iaddr_o);
    end
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL bp_end_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_overflow();
    int got;
    ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_row(2'b01, 64'h0, 64'h4000 + 64'(i * 4));
      tick();
      if (i == 3) begin
        n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL ovf_full_after4: got %b want 1", full_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL ovf_early_flag: got %b want 0", overflow_o); end
      end
    end
    iretire_i = 2'b00;
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
    n_cmp++; if (drop_cnt_o !== DROP2) begin n_err++; $display("FAIL ovf_drop_cnt: got %0d want %0d", drop_cnt_o, DROP2); end
    ready_i = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (valid_o) begin
        n_cmp++;
        if (iaddr_o !== 64'h4000 + 64'(got * 4)) begin
          n_err++; $display("FAIL ovf_drain_addr%0d: got %h want %h", got, iaddr_o, 64'h4000 + 64'(got * 4));
        end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 4) begin n_err++; $display("FAIL ovf_drain_count: got %0d want 4", got); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL ovf_drained_full: got %b want 0", full_o); end
  endtask

  task automatic test_full_pop();
    int got;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    ready_i = 1'b0;
    drive_row(2'b11, 64'h5004, 64'h5000);
    tick();
    drive_row(2'b01, 64'h0, 64'h5008);
    tick();
    drive_row(2'b01, 64'h0, 64'h500C);
    tick();
    drive_row(2'b01, 64'h0, 64'h5010);
    tick();
    iretire_i = 2'b00;
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL fp_full: got %b want 1", full_o); end
    ready_i = 1'b1;
    tick();
    n_cmp++; if (slot_o !== 1'b1 || iaddr_o !== 64'h5004) begin
      n_err++; $display("FAIL fp_head_last: got s=%0d a=%h want s=1 a=5004", slot_o, iaddr_o);
    end
    drive_row(2'b01, 64'h0, 64'h5014);
    tick();
    iretire_i = 2'b00;
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL fp_full_kept: got %b want 1", full_o); end
    n_cmp++; if (drop_cnt_o !== 16'd0) begin n_err++; $display("FAIL fp_drop_cnt: got %0d want 0", drop_cnt_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fp_overflow: got %b want 0", overflow_o); end
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (valid_o) begin
        n_cmp++;
        if (iaddr_o !== 64'h5008 + 64'(got * 4)) begin
          n_err++; $display("FAIL fp_drain_addr%0d: got %h want %h", got, iaddr_o, 64'h5008 + 64'(got * 4));
        end
        got++;
      end
      tick();
    end
    n_cmp++; if (got !== 4) begin n_err++; $display("FAIL fp_drain_count: got %0d want 4", got); end
  endtask

  task automatic test_flush();
    ready_i = 1'b0;
    drive_row(2'b11, 64'h6004, 64'h6000);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_row(2'b01, 64'h0, 64'h6008 + 64'(i * 4));
      tick();
    end
    iretire_i = 2'b00;
    n_cmp++; if (valid_o !== 1'b1 || overflow_o !== 1'b1 || full_o !== 1'b1) begin
      n_err++; $display("FAIL flush_pre: got v=%b o=%b f=%b want 1/1/1", valid_o, overflow_o, full_o);
    end
    n_cmp++; if (drop_cnt_o !== DROP1) begin n_err++; $display("FAIL flush_pre_drop: got %0d want %0d", drop_cnt_o, DROP1); end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", valid_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL flush_full: got %b want 0", full_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL flush_overflow: got %b want 0", overflow_o); end
    n_cmp++; if (drop_cnt_o !== 16'd0) begin n_err++; $display("FAIL flush_drop_cnt: got %0d want 0", drop_cnt_o); end
    ready_i = 1'b1;
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL flush_no_replay: got %b want 0", valid_o); end
  endtask

  task automatic test_reset_midrow();
    ready_i = 1'b0;
    drive_row(2'b11, 64'h7004, 64'h7000);
    itype_i[0] = 3'd4;
    cause_i    = 5'd9;
    tick();
    iretire_i = 2'b00;
    n_cmp++; if (valid_o !== 1'b1 || iaddr_o !== 64'h7000) begin
      n_err++; $display("FAIL rst_pre: got v=%b a=%h want v=1 a=7000", valid_o, iaddr_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_async_valid: got %b want 0", valid_o); end
    n_cmp++; if (iaddr_o !== '0 || itype_o !== '0 || cause_o !== '0) begin
      n_err++; $display("FAIL rst_async_data: got a=%h t=%0d c=%0d want 0", iaddr_o, itype_o, cause_o);
    end
    n_cmp++; if (full_o !== 1'b0 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0 || slot_o !== 1'b0) begin
      n_err++; $display("FAIL rst_async_status: got f=%b o=%b d=%0d s=%0d want 0", full_o, overflow_o, drop_cnt_o, slot_o);
    end
    tick();
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    tick();
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL rst_no_replay: got %b want 0", valid_o); end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    iretire_i   = '0;
    ilastsize_i = '0;
    itype_i     = '0;
    iaddr_i     = '0;
    cause_i     = '0;
    tval_i      = '0;
    priv_i      = '0;
    ready_i     = 1'b0;
    test_reset();
    test_single_row();
    test_sparse();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_flush();
    test_reset_midrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
